// File: rtl/cw_keyer_pkg.sv
// Shared constants, state encoding and speed clamp for the CW iambic keyer.
package cw_keyer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOT  = 2'd1,
    ST_DASH = 2'd2,
    ST_GAP  = 2'd3
  } keyer_state_e;

  localparam logic [10:0] UNIT_THRESHOLD = 11'd1200;
  localparam logic [5:0]  WPM_MIN        = 6'd1;
  localparam logic [5:0]  WPM_MAX        = 6'd60;

  function automatic logic [5:0] clamp_wpm(input logic [5:0] wpm);
    if (wpm < WPM_MIN) begin
      return WPM_MIN;
    end else if (wpm > WPM_MAX) begin
      return WPM_MAX;
    end else begin
      return wpm;
    end
  endfunction

endpackage

// File: rtl/cw_paddle_debounce.sv
// Two-flop synchroniser plus ms-tick debounce filter for one active-low paddle.
module cw_paddle_debounce
  import cw_keyer_pkg::*;
#(
  parameter int DEBOUNCE_MS = 4
) (
  input  logic aclk,
  input  logic resetn,
  input  logic ms_tick,
  input  logic paddle_n,
  output logic pressed
);

  localparam int CW = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic          meta_r;
  logic          sync_r;
  logic          pressed_r;
  logic [CW-1:0] cnt_r;

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= ~paddle_n;
      sync_r <= meta_r;
    end
  end

  // Count ticks at the new level; any return to the accepted level restarts it.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      cnt_r     <= '0;
      pressed_r <= 1'b0;
    end else if (sync_r == pressed_r) begin
      cnt_r <= '0;
    end else if (ms_tick) begin
      if (cnt_r == CNT_LAST) begin
        pressed_r <= sync_r;
        cnt_r     <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign pressed = pressed_r;

endmodule

// File: rtl/cw_iambic_keyer.sv
// Iambic (mode A/B) Morse keyer: debounced paddles, WPM-timed elements, registered key output.
module cw_iambic_keyer
  import cw_keyer_pkg::*;
#(
  parameter int MILLISEC_COUNT = 12287,
  parameter int DEBOUNCE_MS    = 4
) (
  input  logic       aclk,
  input  logic       resetn,
  input  logic       dot_paddle_n,
  input  logic       dash_paddle_n,
  input  logic       keyer_enable,
  input  logic       iambic_mode_b,
  input  logic       reverse_paddles,
  input  logic [5:0] keyer_speed,
  output logic       key_down,
  output logic       keyer_busy
);

  localparam int MSW = (MILLISEC_COUNT < 1) ? 1 : $clog2(MILLISEC_COUNT + 1);
  localparam logic [MSW-1:0] MS_LAST = MSW'(MILLISEC_COUNT);

  logic [MSW-1:0] ms_cnt_r;
  logic           ms_tick_s;
  logic           dot_db_s, dash_db_s, dot_s, dash_s;
  keyer_state_e   state_r, state_nxt_s;
  logic [5:0]     wpm_s;
  logic [10:0]    acc_r, acc_wrap_s;
  logic [11:0]    acc_sum_s;
  logic           unit_end_s;
  logic [1:0]     unit_cnt_r;
  logic           last_dash_r, dot_mem_r, dash_mem_r;
  logic           elem_entry_s, key_on_s, key_down_r;

  assign ms_tick_s = (ms_cnt_r == MS_LAST);

  // The ms grid restarts on element entry so every element spans whole units.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      ms_cnt_r <= '0;
    end else if (elem_entry_s || ms_tick_s) begin
      ms_cnt_r <= '0;
    end else begin
      ms_cnt_r <= ms_cnt_r + MSW'(1);
    end
  end

  cw_paddle_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_dot_db (
    .aclk(aclk), .resetn(resetn), .ms_tick(ms_tick_s), .paddle_n(dot_paddle_n), .pressed(dot_db_s)
  );

  cw_paddle_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_dash_db (
    .aclk(aclk), .resetn(resetn), .ms_tick(ms_tick_s), .paddle_n(dash_paddle_n), .pressed(dash_db_s)
  );

  assign dot_s      = reverse_paddles ? dash_db_s : dot_db_s;
  assign dash_s     = reverse_paddles ? dot_db_s  : dash_db_s;
  assign wpm_s      = clamp_wpm(keyer_speed);
  assign acc_sum_s  = {1'b0, acc_r} + {6'd0, wpm_s};
  assign acc_wrap_s = acc_sum_s[10:0] - UNIT_THRESHOLD;
  assign unit_end_s = ms_tick_s && (acc_sum_s >= {1'b0, UNIT_THRESHOLD});
  assign elem_entry_s = ((state_nxt_s == ST_DOT) || (state_nxt_s == ST_DASH)) &&
                        ((state_r == ST_IDLE) || (state_r == ST_GAP));

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  always_comb begin
    state_nxt_s = state_r;
    if (!keyer_enable) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dot_s)       state_nxt_s = ST_DOT;
          else if (dash_s) state_nxt_s = ST_DASH;
          else             state_nxt_s = ST_IDLE;
        end
        ST_DOT: begin
          if (unit_end_s) state_nxt_s = ST_GAP;
          else            state_nxt_s = ST_DOT;
        end
        ST_DASH: begin
          if (unit_end_s && (unit_cnt_r == 2'd2)) state_nxt_s = ST_GAP;
          else                                    state_nxt_s = ST_DASH;
        end
        ST_GAP: begin
          if (!unit_end_s) begin
            state_nxt_s = ST_GAP;
          end else if (last_dash_r) begin
            if (dot_s || (iambic_mode_b && dot_mem_r)) state_nxt_s = ST_DOT;
            else if (dash_s)                           state_nxt_s = ST_DASH;
            else                                       state_nxt_s = ST_IDLE;
          end else begin
            if (dash_s || (iambic_mode_b && dash_mem_r)) state_nxt_s = ST_DASH;
            else if (dot_s)                              state_nxt_s = ST_DOT;
            else                                         state_nxt_s = ST_IDLE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_on_s   = keyer_enable && ((state_r == ST_DOT) || (state_r == ST_DASH));
    keyer_busy = (state_r != ST_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      acc_r      <= 11'd0;
      unit_cnt_r <= 2'd0;
    end else if (elem_entry_s) begin
      acc_r      <= 11'd0;
      unit_cnt_r <= 2'd0;
    end else if ((state_r != ST_IDLE) && ms_tick_s) begin
      if (unit_end_s) begin
        acc_r      <= acc_wrap_s;
        unit_cnt_r <= unit_cnt_r + 2'd1;
      end else begin
        acc_r <= acc_sum_s[10:0];
      end
    end
  end

  // Squeeze memories: a paddle pressed during the opposite element is remembered for mode B.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      dot_mem_r   <= 1'b0;
      dash_mem_r  <= 1'b0;
      last_dash_r <= 1'b0;
    end else if (state_nxt_s == ST_IDLE) begin
      dot_mem_r  <= 1'b0;
      dash_mem_r <= 1'b0;
    end else begin
      if (elem_entry_s) last_dash_r <= (state_nxt_s == ST_DASH);
      if (elem_entry_s && (state_nxt_s == ST_DOT))   dot_mem_r <= 1'b0;
      else if ((state_r == ST_DASH) && dot_s)        dot_mem_r <= 1'b1;
      if (elem_entry_s && (state_nxt_s == ST_DASH))  dash_mem_r <= 1'b0;
      else if ((state_r == ST_DOT) && dash_s)        dash_mem_r <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      key_down_r <= 1'b0;
    end else begin
      key_down_r <= key_on_s;
    end
  end

  assign key_down = key_down_r;

endmodule

// File: tb/tb_cw_iambic_keyer.sv
// Self-checking bench for cw_iambic_keyer: element-level model per scenario plus literal pins.
module tb_cw_iambic_keyer;

  localparam int MS   = 9;
  localparam int P    = MS + 1;
  localparam int DB   = 4;
  localparam int NMAX = 4500;

  logic       aclk = 1'b0;
  logic       resetn = 1'b0;
  logic       dot_paddle_n = 1'b1;
  logic       dash_paddle_n = 1'b1;
  logic       keyer_enable = 1'b1;
  logic       iambic_mode_b = 1'b0;
  logic       reverse_paddles = 1'b0;
  logic [5:0] keyer_speed = 6'd20;
  logic       key_down;
  logic       keyer_busy;

  int n_checks = 0;
  int n_err = 0;

  bit st_dot  [0:NMAX];
  bit st_dash [0:NMAX];
  bit exp_key [0:NMAX];
  bit exp_busy[0:NMAX];

  cw_iambic_keyer #(.MILLISEC_COUNT(MS), .DEBOUNCE_MS(DB)) dut (
    .aclk(aclk), .resetn(resetn), .dot_paddle_n(dot_paddle_n), .dash_paddle_n(dash_paddle_n),
    .keyer_enable(keyer_enable), .iambic_mode_b(iambic_mode_b), .reverse_paddles(reverse_paddles),
    .keyer_speed(keyer_speed), .key_down(key_down), .keyer_busy(keyer_busy)
  );

  always #5 aclk = ~aclk;

  function automatic void chk(input string what, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endfunction

  function automatic void clear_stim();
    for (int i = 0; i <= NMAX; i++) begin
      st_dot[i]  = 1'b0;
      st_dash[i] = 1'b0;
    end
  endfunction

  function automatic void press(input bit is_dash, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      if (is_dash) st_dash[i] = 1'b1;
      else         st_dot[i]  = 1'b1;
    end
  endfunction

  // Element-level model: paddles accepted after DB whole ms at a new level,
  // elements last 1 or 3 units of 1200/wpm ms, gaps 1 unit, iambic choice at gap end.
  function automatic void build_model(input int len, input int wpm, input bit mb, input bit rev);
    int w, u, anchor, rem, run_d, run_h, ph, go;
    bit db_d, db_h, m_dot, m_dash, last_dash, tick, sd, sh, pd, pa, opp, same;
    w = (wpm < 1) ? 1 : ((wpm > 60) ? 60 : wpm);
    u = 1200 / w;
    anchor = 0; rem = 0; run_d = 0; run_h = 0; ph = 0;
    db_d = 0; db_h = 0; m_dot = 0; m_dash = 0; last_dash = 0;
    for (int e = 1; e <= len; e++) begin
      tick = ((e - anchor) % P) == 0;
      sd = (e >= 3) ? st_dot[e-2]  : 1'b0;
      sh = (e >= 3) ? st_dash[e-2] : 1'b0;
      pd = rev ? db_h : db_d;
      pa = rev ? db_d : db_h;
      exp_key[e] = (ph == 1) || (ph == 2);
      if (ph == 1 && pa) m_dash = 1'b1;
      if (ph == 2 && pd) m_dot = 1'b1;
      go = 0;
      if (ph == 0) begin
        if (pd) go = 1;
        else if (pa) go = 2;
      end else if (tick) begin
        rem--;
        if (rem == 0 && ph != 3) begin
          ph = 3;
          rem = u;
        end else if (rem == 0) begin
          opp  = last_dash ? (pd || (mb && m_dot)) : (pa || (mb && m_dash));
          same = last_dash ? pa : pd;
          if (opp)       go = last_dash ? 1 : 2;
          else if (same) go = last_dash ? 2 : 1;
          else begin
            ph = 0; m_dot = 0; m_dash = 0;
          end
        end
      end
      if (go != 0) begin
        ph = go;
        rem = (go == 1) ? u : 3 * u;
        anchor = e;
        last_dash = (go == 2);
        if (go == 1) m_dot = 1'b0;
        else         m_dash = 1'b0;
      end
      if (sd != db_d) begin
        if (tick) begin
          run_d++;
          if (run_d == DB) begin db_d = sd; run_d = 0; end
        end
      end else run_d = 0;
      if (sh != db_h) begin
        if (tick) begin
          run_h++;
          if (run_h == DB) begin db_h = sh; run_h = 0; end
        end
      end else run_h = 0;
      exp_busy[e] = (ph != 0);
    end
  endfunction

  task automatic do_reset(input int wpm, input bit mb, input bit rev);
    resetn = 1'b0;
    dot_paddle_n = 1'b1;
    dash_paddle_n = 1'b1;
    keyer_enable = 1'b1;
    iambic_mode_b = mb;
    reverse_paddles = rev;
    keyer_speed = 6'(wpm);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_key", int'(key_down), 0);
    chk("reset_busy", int'(keyer_busy), 0);
    resetn = 1'b1;
  endtask

  task automatic run_scn(input string name, input int len, input int wpm, input bit mb, input bit rev,
                         input int lit_high, input int lit_rises, input int lit_busy);
    int high, rises, busy, mhigh;
    bit prev;
    build_model(len, wpm, mb, rev);
    do_reset(wpm, mb, rev);
    high = 0; rises = 0; busy = 0; mhigh = 0; prev = 1'b0;
    for (int e = 1; e <= len; e++) begin
      dot_paddle_n  = ~st_dot[e];
      dash_paddle_n = ~st_dash[e];
      @(posedge aclk);
      @(negedge aclk);
      chk($sformatf("%s key@%0d", name, e), int'(key_down), int'(exp_key[e]));
      chk($sformatf("%s busy@%0d", name, e), int'(keyer_busy), int'(exp_busy[e]));
      if (key_down) high++;
      if (key_down && !prev) rises++;
      if (keyer_busy) busy++;
      if (exp_key[e]) mhigh++;
      prev = key_down;
    end
    chk({name, " model_high"}, mhigh, lit_high);
    chk({name, " high_cycles"}, high, lit_high);
    chk({name, " pulses"}, rises, lit_rises);
    chk({name, " busy_cycles"}, busy, lit_busy);
  endtask

  initial begin
    // Dot held 200 ms at 20 WPM: two 60 ms dots, idle after the trailing gap.
    clear_stim(); press(1'b0, 5, 2005);
    run_scn("dot_hold", 2500, 20, 1'b0, 1'b0, 1200, 2, 2400);

    // 10 ms dash tap at 12 WPM: one 300 ms dash, 100 ms gap.
    clear_stim(); press(1'b1, 5, 105);
    run_scn("dash_tap", 4100, 12, 1'b0, 1'b0, 3000, 1, 4000);

    // Squeeze released 20 ms into the first dot, mode B then mode A.
    clear_stim(); press(1'b0, 5, 241); press(1'b1, 5, 241);
    run_scn("squeeze_b", 3700, 20, 1'b1, 1'b0, 2400, 2, 3600);
    run_scn("squeeze_a", 1300, 20, 1'b0, 1'b0, 600, 1, 1200);

    // 2 ms glitch is filtered out.
    clear_stim(); press(1'b0, 5, 25);
    run_scn("glitch", 300, 20, 1'b0, 1'b0, 0, 0, 0);

    // Reversed paddles, speed 63 clamps to 60 WPM (20 ms unit).
    clear_stim(); press(1'b1, 5, 300);
    run_scn("rev_fast", 500, 63, 1'b1, 1'b0 | 1'b1, 200, 1, 400);

    // Dash with a dot tap during it: mode B plays the remembered dot.
    clear_stim(); press(1'b1, 5, 100); press(1'b0, 500, 600);
    run_scn("dot_mem", 3700, 20, 1'b1, 1'b0, 2400, 2, 3600);

    // Enable dropped mid-dash.
    do_reset(20, 1'b0, 1'b0);
    dash_paddle_n = 1'b0;
    repeat (500) @(posedge aclk);
    @(negedge aclk);
    chk("pre_disable_key", int'(key_down), 1);
    keyer_enable = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("disable_key", int'(key_down), 0);
    chk("disable_busy", int'(keyer_busy), 0);
    dash_paddle_n = 1'b1;
    repeat (100) @(posedge aclk);
    @(negedge aclk);
    keyer_enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      chk($sformatf("reenable_idle@%0d", i), int'(keyer_busy | key_down), 0);
    end

    // Reset dropped mid-dash.
    dash_paddle_n = 1'b0;
    repeat (300) @(posedge aclk);
    @(negedge aclk);
    chk("pre_reset_key", int'(key_down), 1);
    resetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("midreset_key", int'(key_down), 0);
    chk("midreset_busy", int'(keyer_busy), 0);
    dash_paddle_n = 1'b1;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge aclk);
      @(negedge aclk);
      chk($sformatf("post_reset_idle@%0d", i), int'(keyer_busy | key_down), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
